icmp_echo_tx: RTL and testbench

GMII-side transmitter that builds and sends a complete ICMP echo-reply Ethernet frame when pulsed with the identifier and sequence number captured by the ICMP receiver. It emits preamble/SFD, Ethernet header, IPv4 header, ICMP header, a fixed payload and the IEEE 802.3 FCS, followed by an inter-frame gap. It sits between the ICMP receive path and the GMII/RGMII output mux.

---
 rtl/icmp_echo_tx.sv | 198 +++++++++++++++++++
 tb/tb_icmp_echo_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_echo_tx.sv
// ICMP echo-reply frame generator on the GMII transmit side: preamble, Ethernet/IPv4/ICMP
// headers, fixed payload and FCS, then an inter-frame gap before the next start is taken.
module icmp_echo_tx #(
  parameter logic [47:0] LOCAL_MAC     = 48'h000a_3501_fec0,
  parameter logic [47:0] PEER_MAC      = 48'hffff_ffff_ffff,
  parameter logic [31:0] LOCAL_IP      = 32'hc0a8_010a,
  parameter logic [31:0] PEER_IP       = 32'hc0a8_0166,
  parameter int          PAYLOAD_BYTES = 32,
  parameter int          IFG_CYCLES    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icmp_tx_start,
  input  logic [15:0] identify,
  input  logic [15:0] sequence_num,  // "sequence" is a reserved word
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        icmp_tx_busy,
  output logic        icmp_tx_end
);

  typedef enum logic [3:0] {
    S_IDLE, S_CALC, S_PREAMBLE, S_ETH_HEAD, S_IP_HEAD,
    S_ICMP_HEAD, S_PAYLOAD, S_FCS, S_IFG
  } state_t;

  function automatic logic [31:0] payload_sum(input int n);
    logic [31:0] s;
    logic [7:0]  b;
    s = '0;
    for (int k = 0; k < n; k++) begin
      b = 8'(32'h61 + 32'(k % 23));
      if (k % 2 == 0) s = s + {16'h0000, b, 8'h00};
      else            s = s + {24'h000000, b};
    end
    return s;
  endfunction

  function automatic logic [15:0] csum_finish(input logic [31:0] s);
    logic [31:0] f;
    f = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    f = {16'h0000, f[15:0]} + {16'h0000, f[31:16]};
    return ~f[15:0];
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hedb8_8320) : (r >> 1);
    return r;
  endfunction

  localparam logic [31:0] PAY_SUM    = payload_sum(PAYLOAD_BYTES);
  localparam logic [15:0] IP_TOT_LEN = 16'(28 + PAYLOAD_BYTES);
  localparam logic [10:0] PAY_LAST   = 11'(PAYLOAD_BYTES - 1);
  localparam logic [10:0] IFG_LAST   = 11'(IFG_CYCLES - 1);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [4:0]  pay_mod_q, pay_mod_d;
  logic [15:0] id_q, id_d, seq_q, seq_d, ip_id_q, ip_id_d;
  logic [15:0] ip_csum_q, ip_csum_d, icmp_csum_q, icmp_csum_d;
  logic [31:0] crc_q, crc_d;
  logic        tx_en_q, tx_en_d, end_q, end_d;
  logic [7:0]  txd_q, txd_d;

  logic [7:0]        cur_byte;
  logic [31:0]       ip_sum, icmp_sum, fcs;
  logic [0:13][7:0]  eth_b;
  logic [0:19][7:0]  ip_b;
  logic [0:7][7:0]   icmp_b;

  assign ip_sum = 32'h4500 + {16'h0000, IP_TOT_LEN} + {16'h0000, ip_id_q} + 32'h4001
                + {16'h0000, LOCAL_IP[31:16]} + {16'h0000, LOCAL_IP[15:0]}
                + {16'h0000, PEER_IP[31:16]} + {16'h0000, PEER_IP[15:0]};
  assign icmp_sum = {16'h0000, id_q} + {16'h0000, seq_q} + PAY_SUM;

  assign eth_b  = {PEER_MAC, LOCAL_MAC, 16'h0800};
  assign ip_b   = {8'h45, 8'h00, IP_TOT_LEN, ip_id_q, 16'h0000, 8'h40, 8'h01,
                   ip_csum_q, LOCAL_IP, PEER_IP};
  assign icmp_b = {16'h0000, icmp_csum_q, id_q, seq_q};
  assign fcs    = ~crc_q;

  always_comb begin
    state_d     = state_q;
    pay_mod_d   = pay_mod_q;
    id_d        = id_q;
    seq_d       = seq_q;
    ip_id_d     = ip_id_q;
    ip_csum_d   = ip_csum_q;
    icmp_csum_d = icmp_csum_q;
    crc_d       = crc_q;
    tx_en_d     = 1'b0;
    end_d       = 1'b0;
    cur_byte    = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (icmp_tx_start) begin
          state_d = S_CALC;
          id_d    = identify;
          seq_d   = sequence_num;
        end
      end
      S_CALC: begin
        ip_csum_d   = csum_finish(ip_sum);
        icmp_csum_d = csum_finish(icmp_sum);
        crc_d       = 32'hffff_ffff;
        pay_mod_d   = '0;
        state_d     = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        tx_en_d  = 1'b1;
        cur_byte = (cnt_q == 11'd7) ? 8'hd5 : 8'h55;
        if (cnt_q == 11'd7) state_d = S_ETH_HEAD;
      end
      S_ETH_HEAD: begin
        tx_en_d  = 1'b1;
        cur_byte = eth_b[cnt_q[3:0]];
        if (cnt_q == 11'd13) state_d = S_IP_HEAD;
      end
      S_IP_HEAD: begin
        tx_en_d  = 1'b1;
        cur_byte = ip_b[cnt_q[4:0]];
        if (cnt_q == 11'd19) state_d = S_ICMP_HEAD;
      end
      S_ICMP_HEAD: begin
        tx_en_d  = 1'b1;
        cur_byte = icmp_b[cnt_q[2:0]];
        if (cnt_q == 11'd7) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        tx_en_d   = 1'b1;
        cur_byte  = 8'h61 + {3'b000, pay_mod_q};
        pay_mod_d = (pay_mod_q == 5'd22) ? 5'd0 : pay_mod_q + 5'd1;
        if (cnt_q == PAY_LAST) state_d = S_FCS;
      end
      S_FCS: begin
        tx_en_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    cur_byte = fcs[7:0];
          2'd1:    cur_byte = fcs[15:8];
          2'd2:    cur_byte = fcs[23:16];
          default: cur_byte = fcs[31:24];
        endcase
        if (cnt_q == 11'd3) state_d = S_IFG;
      end
      S_IFG: begin
        // last FCS byte leaves the output register on this cycle's edge
        if (cnt_q == 11'd0) begin
          end_d   = 1'b1;
          ip_id_d = ip_id_q + 16'd1;
        end
        if (cnt_q == IFG_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q inside {S_ETH_HEAD, S_IP_HEAD, S_ICMP_HEAD, S_PAYLOAD})
      crc_d = crc_byte(crc_q, cur_byte);
    txd_d = tx_en_d ? cur_byte : 8'h00;
    cnt_d = (state_d != state_q || state_q == S_IDLE) ? 11'd0 : cnt_q + 11'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pay_mod_q   <= '0;
      id_q        <= '0;
      seq_q       <= '0;
      ip_id_q     <= '0;
      ip_csum_q   <= '0;
      icmp_csum_q <= '0;
      crc_q       <= 32'hffff_ffff;
      tx_en_q     <= 1'b0;
      txd_q       <= 8'h00;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pay_mod_q   <= pay_mod_d;
      id_q        <= id_d;
      seq_q       <= seq_d;
      ip_id_q     <= ip_id_d;
      ip_csum_q   <= ip_csum_d;
      icmp_csum_q <= icmp_csum_d;
      crc_q       <= crc_d;
      tx_en_q     <= tx_en_d;
      txd_q       <= txd_d;
      end_q       <= end_d;
    end
  end

  assign gmii_tx_en   = tx_en_q;
  assign gmii_txd     = txd_q;
  assign icmp_tx_end  = end_q;
  assign icmp_tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_icmp_echo_tx.sv
// Bench for icmp_echo_tx: captures each transmitted frame and compares it against a frame
// assembled byte-by-byte from the protocol rules, plus timing, reset and start-filter checks.
module tb_icmp_echo_tx;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [47:0] LOCAL_MAC = 48'h000a_3501_fec0;
  localparam logic [47:0] PEER_MAC  = 48'hffff_ffff_ffff;
  localparam logic [31:0] LOCAL_IP  = 32'hc0a8_010a;
  localparam logic [31:0] PEER_IP   = 32'hc0a8_0166;
  localparam int          PAY       = 32;
  localparam int          BUDGET    = 3000;

  logic        clk, rst_n, icmp_tx_start;
  logic [15:0] identify, sequence_num;
  logic        gmii_tx_en, icmp_tx_busy, icmp_tx_end;
  logic [7:0]  gmii_txd;

  int      n_pass = 0, n_total = 0;
  byte_q_t cap, exp_q;
  logic [15:0] exp_ipid;

  icmp_echo_tx dut (
    .clk(clk), .rst_n(rst_n), .icmp_tx_start(icmp_tx_start),
    .identify(identify), .sequence_num(sequence_num),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .icmp_tx_busy(icmp_tx_busy), .icmp_tx_end(icmp_tx_end)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] crc_raw(input byte_q_t q, input int from);
    logic [31:0] c = 32'hffff_ffff;
    for (int i = from; i < q.size(); i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] inet_csum(input byte_q_t q);
    longint s = 0;
    for (int i = 0; i < q.size(); i += 2)
      s += (longint'(q[i]) << 8) + ((i + 1 < q.size()) ? longint'(q[i+1]) : 64'd0);
    while ((s >> 16) != 0) s = (s & 64'hffff) + (s >> 16);
    return ~16'(s);
  endfunction

  function automatic void build_frame(input logic [15:0] ipid, input logic [15:0] ident,
                                      input logic [15:0] seq);
    byte_q_t ip, ic;
    logic [15:0] cs;
    logic [31:0] crc;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(PEER_MAC >> (8*i)));
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(LOCAL_MAC >> (8*i)));
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    ip = '{8'h45, 8'h00, 8'((28 + PAY) >> 8), 8'(28 + PAY), ipid[15:8], ipid[7:0],
           8'h00, 8'h00, 8'h40, 8'h01, 8'h00, 8'h00};
    for (int i = 3; i >= 0; i--) ip.push_back(8'(LOCAL_IP >> (8*i)));
    for (int i = 3; i >= 0; i--) ip.push_back(8'(PEER_IP >> (8*i)));
    cs = inet_csum(ip);
    ip[10] = cs[15:8]; ip[11] = cs[7:0];
    ic = '{8'h00, 8'h00, 8'h00, 8'h00, ident[15:8], ident[7:0], seq[15:8], seq[7:0]};
    for (int k = 0; k < PAY; k++) ic.push_back(8'(8'h61 + k % 23));
    cs = inet_csum(ic);
    ic[2] = cs[15:8]; ic[3] = cs[7:0];
    foreach (ip[i]) exp_q.push_back(ip[i]);
    foreach (ic[i]) exp_q.push_back(ic[i]);
    crc = ~crc_raw(exp_q, 8);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(crc >> (8*i)));
  endfunction

  // Launch one start and follow the DUT until busy drops (or reset_at bytes were captured).
  task automatic run_frame(input logic [15:0] ident, input logic [15:0] seq,
                           input int inject_at, input int reset_at, output int ends);
    int cyc, rises;
    logic prev_en;
    cap.delete();
    ends = 0; rises = 0; prev_en = 1'b0;
    identify = ident; sequence_num = seq; icmp_tx_start = 1'b1;
    @(negedge clk);
    icmp_tx_start = 1'b0;
    chk("busy_after_start", {31'h0, icmp_tx_busy}, 1);
    chk("en_low_at_N", {31'h0, gmii_tx_en}, 0);
    @(negedge clk);
    chk("en_low_in_calc", {31'h0, gmii_tx_en}, 0);
    cyc = 0;
    while (cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("en_latency", {31'h0, gmii_tx_en}, 1);
      if (gmii_tx_en) begin
        if (!prev_en) rises++;
        cap.push_back(gmii_txd);
      end else begin
        chk("txd_zero_idle", {24'h0, gmii_txd}, 0);
        if (prev_en) chk("end_on_fall", {31'h0, icmp_tx_end}, 1);
      end
      if (icmp_tx_end) ends++;
      prev_en = gmii_tx_en;
      icmp_tx_start = (inject_at >= 0 && gmii_tx_en && cap.size() == inject_at);
      if (reset_at >= 0 && cap.size() == reset_at) begin
        rst_n = 1'b0;
        break;
      end
      if (!icmp_tx_busy) break;
    end
    icmp_tx_start = 1'b0;
    chk("frame_in_budget", {31'h0, cyc < BUDGET}, 1);
    if (reset_at < 0) chk("en_single_burst", rises, 1);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i),
          (i < cap.size()) ? {24'h0, cap[i]} : 32'hffff_ffff, {24'h0, exp_q[i]});
    if (cap.size() > 8) chk({tag, "_residue"}, crc_raw(cap, 8), 32'hdebb_20e3);
  endtask

  function automatic logic [15:0] cap16(input int i);
    return (i + 1 < cap.size()) ? {cap[i], cap[i+1]} : 16'hxxxx;
  endfunction

  initial begin : main
    int ends, rises;
    string pay_str, s9;
    byte_q_t q9;
    logic [15:0] ri, rs;
    logic rx_ok;

    rst_n = 1'b0; icmp_tx_start = 1'b0; identify = '0; sequence_num = '0;
    // reset held with start toggling
    for (int i = 0; i < 5; i++) begin
      icmp_tx_start = ~icmp_tx_start;
      @(negedge clk);
      chk("reset_outputs", {20'h0, gmii_tx_en, gmii_txd, icmp_tx_busy, icmp_tx_end}, 0);
    end
    icmp_tx_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    exp_ipid = 16'h0000;

    // CRC reference check
    s9 = "123456789";
    for (int i = 0; i < s9.len(); i++) q9.push_back(s9[i]);
    chk("crc_check_value", ~crc_raw(q9, 0), 32'hcbf4_3926);

    // frame 1: documented values
    run_frame(16'h0001, 16'h0005, -1, -1, ends);
    chk("f1_ends", ends, 1);
    chk("f1_len86", cap.size(), 86);
    for (int i = 0; i < 8; i++) chk("f1_preamble", {24'h0, cap[i]}, (i == 7) ? 32'hd5 : 32'h55);
    chk("f1_ethtype", {16'h0, cap16(20)}, 32'h0800);
    chk("f1_totlen", {16'h0, cap16(24)}, 32'h003c);
    chk("f1_ipcsum", {16'h0, cap16(32)}, 32'hf700);
    chk("f1_icmp_type_code", {16'h0, cap16(42)}, 32'h0000);
    chk("f1_icmp_ident", {16'h0, cap16(46)}, 32'h0001);
    chk("f1_icmp_seq", {16'h0, cap16(48)}, 32'h0005);
    pay_str = "abcdefghijklmnopqrstuvwabcdefghi";
    for (int k = 0; k < 32; k++)
      chk("f1_payload", (50 + k < cap.size()) ? {24'h0, cap[50+k]} : 32'hffff_ffff,
          {24'h0, pay_str[k]});
    build_frame(exp_ipid, 16'h0001, 16'h0005);
    cmp_frame("f1");
    exp_ipid++;

    // frame 2 with a start injected mid-frame
    run_frame(16'h0002, 16'h0006, 30, -1, ends);
    chk("f2_ends", ends, 1);
    chk("f2_ipid", {16'h0, cap16(26)}, 32'h0001);
    chk("f2_ipcsum", {16'h0, cap16(32)}, 32'hf6ff);
    build_frame(exp_ipid, 16'h0002, 16'h0006);
    cmp_frame("f2");
    exp_ipid++;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gmii_tx_en || icmp_tx_busy) rises++;
    end
    chk("no_third_frame", rises, 0);

    // randomized identifiers and sequence numbers
    for (int r = 0; r < 3; r++) begin
      logic [15:0] id_r, sq_r;
      id_r = 16'($urandom);
      sq_r = 16'($urandom);
      run_frame(id_r, sq_r, -1, -1, ends);
      chk("rnd_ends", ends, 1);
      build_frame(exp_ipid, id_r, sq_r);
      cmp_frame($sformatf("rnd%0d", r));
      exp_ipid++;
    end

    // loopback into a receive-side parser
    run_frame(16'hbeef, 16'h1234, -1, -1, ends);
    build_frame(exp_ipid, 16'hbeef, 16'h1234);
    cmp_frame("lb");
    exp_ipid++;
    if (cap.size() > 49) cap[42] = 8'h08;
    rx_ok = (cap.size() > 49) && cap[7] == 8'hd5 && cap16(20) == 16'h0800 &&
            cap[31] == 8'h01 && cap[42] == 8'h08;
    ri = rx_ok ? cap16(46) : 16'h0000;
    rs = rx_ok ? cap16(48) : 16'h0000;
    chk("rx_end", {31'h0, rx_ok}, 1);
    chk("rx_identify", {16'h0, ri}, 32'hbeef);
    chk("rx_sequence", {16'h0, rs}, 32'h1234);

    // reset during a frame
    run_frame(16'h5555, 16'haaaa, -1, 40, ends);
    @(negedge clk);
    chk("rst_mid_en", {31'h0, gmii_tx_en}, 0);
    chk("rst_mid_busy", {31'h0, icmp_tx_busy}, 0);
    chk("rst_mid_end", {31'h0, icmp_tx_end}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (icmp_tx_end) ends++;
    end
    chk("rst_mid_no_end", ends, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_ipid = 16'h0000;

    run_frame(16'h0bad, 16'hcafe, -1, -1, ends);
    chk("post_rst_ends", ends, 1);
    chk("post_rst_ipid", {16'h0, cap16(26)}, 32'h0000);
    build_frame(exp_ipid, 16'h0bad, 16'hcafe);
    cmp_frame("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
